// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
package div_sched_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } sched_state_t;

  // Number of high cycles in a period of n: ceil(n/2) without overflow.
  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/div_phase_gen.sv
// Phase counter and registered divided-clock/enable outputs; a load emits
// phase 0 of the new ratio on the same edge.
module div_phase_gen
  import div_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             stop,
  input  logic [CNT_W-1:0] n,
  output logic             at_boundary,
  output logic             div_clk,
  output logic             div_en
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // cnt is the phase that the next edge will emit, so cnt == 0 marks the
  // edge that closes one period and opens the next.
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] last_phase;

  always_comb begin
    phase      = load ? '0 : cnt;
    last_phase = n - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      div_en  <= 1'b0;
    end else if (stop) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      div_en  <= 1'b0;
    end else begin
      div_clk <= (32'(phase) < ceil_half(32'(n)));
      div_en  <= (phase == last_phase);
      cnt     <= (phase == last_phase) ? '0 : phase + ONE;
    end
  end

  assign at_boundary = (cnt == '0);

endmodule

// File: rtl/div_ratio_sched.sv
// Divider ratio scheduler: round-robin arbitration between two requesters,
// with new ratios applied only on period boundaries.
module div_ratio_sched
  import div_sched_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             I_CLK,
  input  logic             Rst,
  input  logic [1:0]       req_i,
  input  logic [CNT_W-1:0] div0_i,
  input  logic [CNT_W-1:0] div1_i,
  output logic [1:0]       ack_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cur_div_o,
  output logic             O_EN,
  output logic             O_CLK
);

  localparam logic [CNT_W-1:0] RST_DIV   = CNT_W'(DEFAULT_DIV);
  localparam sched_state_t     RST_STATE = (DEFAULT_DIV == 0) ? STOP : RUN;

  sched_state_t     state;
  logic [CNT_W-1:0] pend_div;
  logic             pend_who;
  logic             last_gnt;

  logic             at_boundary;
  logic [1:0]       elig;
  logic             win_valid;
  logic             win_who;
  logic [CNT_W-1:0] win_div;
  logic             apply_now;
  logic             apply_who;
  logic [CNT_W-1:0] apply_div;
  logic             pg_load;
  logic             pg_stop;
  logic [CNT_W-1:0] pg_n;

  // Requester 1 wins alone, or on a tie when requester 0 was granted last.
  always_comb begin
    elig      = (state == SWITCH) ? 2'b00 : (req_i & ~ack_o);
    win_valid = |elig;
    win_who   = elig[1] && (!elig[0] || !last_gnt);
    win_div   = win_who ? div1_i : div0_i;

    apply_now = 1'b0;
    apply_who = win_who;
    apply_div = win_div;
    case (state)
      SWITCH: begin
        apply_now = at_boundary;
        apply_who = pend_who;
        apply_div = pend_div;
      end
      RUN:     apply_now = win_valid && at_boundary;
      default: apply_now = win_valid;
    endcase

    pg_load = apply_now && (apply_div != '0);
    pg_stop = ((state == STOP) && !pg_load) || (apply_now && (apply_div == '0));
    pg_n    = pg_load ? apply_div : cur_div_o;
  end

  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst) begin
      state     <= RST_STATE;
      cur_div_o <= RST_DIV;
      pend_div  <= '0;
      pend_who  <= 1'b0;
      last_gnt  <= 1'b1;
      ack_o     <= 2'b00;
      busy_o    <= 1'b0;
    end else begin
      ack_o <= 2'b00;
      if (win_valid) last_gnt <= win_who;
      if (apply_now) begin
        cur_div_o <= apply_div;
        ack_o     <= apply_who ? 2'b10 : 2'b01;
        state     <= (apply_div == '0) ? STOP : RUN;
        busy_o    <= 1'b0;
      end else if ((state == RUN) && win_valid) begin
        pend_div <= win_div;
        pend_who <= win_who;
        state    <= SWITCH;
        busy_o   <= 1'b1;
      end
    end
  end

  div_phase_gen #(
    .CNT_W(CNT_W)
  ) u_phase (
    .clk        (I_CLK),
    .rst_n      (Rst),
    .load       (pg_load),
    .stop       (pg_stop),
    .n          (pg_n),
    .at_boundary(at_boundary),
    .div_clk    (O_CLK),
    .div_en     (O_EN)
  );

endmodule

// File: tb/tb_div_ratio_sched.sv
// Self-checking bench for div_ratio_sched: directed scenarios plus random
// requests compared against a period/phase level reference model.
module tb_div_ratio_sched;

  logic        I_CLK = 1'b0;
  logic        Rst = 1'b0;
  logic [1:0]  req_i = 2'b00;
  logic [15:0] div0_i = '0;
  logic [15:0] div1_i = '0;
  logic [1:0]  ack_o;
  logic        busy_o;
  logic [15:0] cur_div_o;
  logic        O_EN;
  logic        O_CLK;

  always #5 I_CLK = ~I_CLK;

  div_ratio_sched #(
    .CNT_W(16),
    .DEFAULT_DIV(4)
  ) dut (
    .I_CLK    (I_CLK),
    .Rst      (Rst),
    .req_i    (req_i),
    .div0_i   (div0_i),
    .div1_i   (div1_i),
    .ack_o    (ack_o),
    .busy_o   (busy_o),
    .cur_div_o(cur_div_o),
    .O_EN     (O_EN),
    .O_CLK    (O_CLK)
  );

  int total = 0;
  int bad = 0;

  // Reference model: m_phase is the phase shown on the outputs (-1 = none yet).
  bit       m_run;
  int       m_div;
  int       m_phase;
  bit       m_pend;
  int       m_pdiv;
  int       m_pwho;
  int       m_last;
  bit [1:0] m_ack;
  bit [1:0] hold = 2'b00;
  bit       rand_mode = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b1;
    m_div = 4;
    m_phase = -1;
    m_pend = 1'b0;
    m_pdiv = 0;
    m_pwho = 0;
    m_last = 1;
    m_ack = 2'b00;
  endtask

  task automatic model_take(input int d);
    m_div = d;
    if (d == 0) begin
      m_run = 1'b0;
      m_phase = -1;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic model_edge();
    bit [1:0] elig;
    bit [1:0] nack;
    bit       starts;
    int       w;
    int       d;
    nack = 2'b00;
    elig = m_pend ? 2'b00 : (req_i & ~m_ack);
    if (elig == 2'b11) w = (m_last == 1) ? 0 : 1;
    else               w = elig[1] ? 1 : 0;
    d = (w == 1) ? int'(div1_i) : int'(div0_i);
    starts = (m_phase < 0) || (m_phase == m_div - 1);
    if (elig != 2'b00) m_last = w;
    if (!m_run) begin
      if (elig != 2'b00) begin
        nack[w] = 1'b1;
        m_div = d;
        if (d != 0) begin
          m_run = 1'b1;
          m_phase = 0;
        end
      end
    end else if (m_pend) begin
      if (starts) begin
        nack[m_pwho] = 1'b1;
        model_take(m_pdiv);
        m_pend = 1'b0;
      end else begin
        m_phase++;
      end
    end else if ((elig != 2'b00) && starts) begin
      nack[w] = 1'b1;
      model_take(d);
    end else begin
      if (elig != 2'b00) begin
        m_pend = 1'b1;
        m_pdiv = d;
        m_pwho = w;
      end
      m_phase = starts ? 0 : m_phase + 1;
    end
    m_ack = nack;
  endtask

  task automatic compare_all();
    bit ec;
    bit ee;
    ec = m_run && (m_phase >= 0) && (m_phase < (m_div + 1) / 2);
    ee = m_run && (m_phase >= 0) && (m_phase == m_div - 1);
    checkOutput("o_clk", 32'(O_CLK), 32'(ec));
    checkOutput("o_en", 32'(O_EN), 32'(ee));
    checkOutput("ack", 32'(ack_o), 32'(m_ack));
    checkOutput("busy", 32'(busy_o), 32'(m_pend));
    checkOutput("cur_div", 32'(cur_div_o), 32'(m_div));
  endtask

  // One clock: model steps on the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge I_CLK);
    model_edge();
    @(negedge I_CLK);
    compare_all();
    for (int i = 0; i < 2; i++) begin
      if (m_ack[i]) begin
        if (!hold[i]) req_i[i] = 1'b0;
        hold[i] = 1'b0;
      end else if (rand_mode && m_pend && (m_pwho == i) && ($urandom % 3 == 0)) begin
        req_i[i] = 1'b0;
      end
    end
  endtask

  // Called just after a falling edge; releases before the next rising edge.
  task automatic do_reset();
    #1 Rst = 1'b0;
    req_i = 2'b00;
    hold = 2'b00;
    model_reset();
    #1 compare_all();
    checkOutput("rst_cur_div", 32'(cur_div_o), 32'd4);
    checkOutput("rst_ack", 32'(ack_o), 32'd0);
    #1 Rst = 1'b1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [15:0] d0, input logic [15:0] d1);
    div0_i = d0;
    div1_i = d1;
    req_i = r;
  endtask

  task automatic wait_ack(input string tag, output logic [1:0] seen, output int n);
    seen = 2'b00;
    n = 0;
    while ((seen == 2'b00) && (n < 64)) begin
      cycle();
      n++;
      seen = ack_o;
    end
    checkOutput({tag, "_ack_seen"}, 32'(seen != 2'b00), 32'd1);
  endtask

  logic [3:0] pat = 4'b0011;
  logic [1:0] seen;
  int         n;
  int         busy_cnt;

  initial begin
    model_reset();
    repeat (2) @(negedge I_CLK);
    compare_all();
    #1 Rst = 1'b1;

    // Default ratio 4: 1,1,0,0 with enable on the last cycle.
    for (int k = 0; k < 8; k++) begin
      cycle();
      checkOutput("t1_clk_pat", 32'(O_CLK), 32'(pat[k % 4]));
      checkOutput("t1_en_pat", 32'(O_EN), 32'(k % 4 == 3));
    end

    // Ratio 3 requested while phase 1 is showing.
    cycle();
    cycle();
    applyStimulus(2'b01, 16'd3, 16'd0);
    busy_cnt = 0;
    seen = 2'b00;
    for (int i = 0; (i < 20) && (seen == 2'b00); i++) begin
      cycle();
      if (busy_o) busy_cnt++;
      seen = ack_o;
    end
    checkOutput("t2_busy_cycles", 32'(busy_cnt), 32'd2);
    checkOutput("t2_ack", 32'(seen), 32'd1);
    checkOutput("t2_cur", 32'(cur_div_o), 32'd3);
    checkOutput("t2_clk_p0", 32'(O_CLK), 32'd1);
    cycle();
    checkOutput("t2_clk_p1", 32'(O_CLK), 32'd1);
    cycle();
    checkOutput("t2_clk_p2", 32'(O_CLK), 32'd0);

    // Stop with ratio 0, then restart with ratio 1.
    applyStimulus(2'b01, 16'd0, 16'd0);
    wait_ack("t4_stop", seen, n);
    checkOutput("t4_stop_ack", 32'(seen), 32'd1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t4_stop_clk", 32'(O_CLK), 32'd0);
      checkOutput("t4_stop_en", 32'(O_EN), 32'd0);
      cycle();
    end
    applyStimulus(2'b10, 16'd0, 16'd1);
    wait_ack("t4_run1", seen, n);
    checkOutput("t4_run1_latency", 32'(n), 32'd1);
    checkOutput("t4_run1_ack", 32'(seen), 32'd2);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4_div1_clk", 32'(O_CLK), 32'd1);
      checkOutput("t4_div1_en", 32'(O_EN), 32'd1);
      cycle();
    end

    // Reset while a change is pending discards it.
    do_reset();
    cycle();
    applyStimulus(2'b01, 16'd3, 16'd0);
    cycle();
    checkOutput("t5_busy", 32'(busy_o), 32'd1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle();
      checkOutput("t5_clk_pat", 32'(O_CLK), 32'(pat[k]));
      checkOutput("t5_no_ack", 32'(ack_o), 32'd0);
    end

    // Ties from a fresh reset: grants alternate 0, 1, then 0 again.
    do_reset();
    applyStimulus(2'b11, 16'd5, 16'd2);
    wait_ack("t6_a", seen, n);
    checkOutput("t6_first_gnt", 32'(seen), 32'd1);
    checkOutput("t6_first_cur", 32'(cur_div_o), 32'd5);
    wait_ack("t6_b", seen, n);
    checkOutput("t6_second_gnt", 32'(seen), 32'd2);
    checkOutput("t6_second_cur", 32'(cur_div_o), 32'd2);
    cycle();
    applyStimulus(2'b11, 16'd3, 16'd4);
    wait_ack("t6_c", seen, n);
    checkOutput("t6_third_gnt", 32'(seen), 32'd1);
    wait_ack("t6_d", seen, n);
    checkOutput("t6_fourth_gnt", 32'(seen), 32'd2);

    // Random traffic against the model.
    rand_mode = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom % 150 == 0) begin
        do_reset();
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (!req_i[i] && ($urandom % 6 == 0)) begin
            if (i == 0) div0_i = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            else        div1_i = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            hold[i] = ($urandom % 4 == 0);
            req_i[i] = 1'b1;
          end
        end
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
